fir_out_fifo_wb: RTL and testbench
==================================

FIR_OUT_FIFO_WB -- requirements
Module: fir_out_fifo_wb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: stream and Wishbone data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: Wishbone address width.
REQ-003 SHALL have parameter DEPTH, default 16: FIFO entries; power of two, range 2..256.
REQ-004 SHALL have port wb_clk_i  in  1  clock, rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset: asynchronous, active-high; clock is wb_clk_i.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone slave cycle, strobe, write-enable.
REQ-007 SHALL have ports wbs_sel_i  in  4  byte select; wbs_adr_i  in  ADDR_WIDTH  address; wbs_dat_i  in  DATA_WIDTH  write data.
REQ-008 SHALL have ports wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  DATA_WIDTH  read data.
REQ-009 SHALL have ports sm_tvalid  in  1, sm_tdata  in  DATA_WIDTH, sm_tlast  in  1: FIR AXI-Stream master output.
REQ-010 SHALL have port sm_tready  out  1  stream ready back to the FIR.
REQ-011 SHALL have port irq_o  out  1  level interrupt.

Function
REQ-012 SHALL store {sm_tlast, sm_tdata} per entry in a circular FIFO of DEPTH entries with wrapping read/write pointers and a count of 0..DEPTH.
REQ-013 SHALL drive sm_tready = !full && !wb_rst_i && !flush_accept, where flush_accept is defined in REQ-020.
REQ-014 SHALL push on every rising edge where sm_tvalid && sm_tready; sm_tdata is never dropped while sm_tready is high.
REQ-015 SHALL decode wbs_adr_i as follows: 0x104 DATA (read); 0x108 STATUS (read); 0x10C CTRL (write). Any other address acks, reads 0, and ignores writes.
REQ-016 SHALL implement a 2-state Wishbone FSM. IDLE -> ACK on an edge with wbs_cyc_i && wbs_stb_i; ACK -> IDLE unconditionally. wbs_ack_o SHALL be high for exactly the one cycle spent in ACK (latency 1 cycle).
REQ-017 SHALL register wbs_dat_o on the IDLE->ACK edge, hold it through ACK, and return it to 0 on the ACK->IDLE edge.
REQ-018 DATA read SHALL return the head entry's data and pop it on the IDLE->ACK edge when non-empty. When empty it SHALL return 0, not pop, and set the sticky underflow flag.
REQ-019 STATUS read SHALL return: bits[8:0] count; bit9 empty; bit10 full; bit11 head tlast (0 when empty); bit12 underflow; bits[31:16] frame_cnt.
REQ-020 CTRL write with wbs_sel_i[0]=1 SHALL act on the IDLE->ACK edge. bit0 flush: pointers and count go to 0; flush_accept is high in that cycle. bit1 clears underflow. bit2 clears frame_cnt. Writes with wbs_sel_i[0]=0 have no effect.
REQ-021 frame_cnt SHALL be 16 bits, increment on every push with sm_tlast=1, and wrap 0xFFFF->0.
REQ-022 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When flush and an increment (push or tlast) coincide, flush and clear SHALL win. The beat is not accepted because sm_tready is low.
REQ-024 A push-with-tlast coinciding with the bit2 clear SHALL leave frame_cnt = 0.
REQ-025 Writes to DATA and STATUS, and reads of CTRL, SHALL ack with no side effect; a CTRL read returns 0.
REQ-026 irq_o SHALL be registered: irq_o = (frame_cnt != 0) || underflow, updated every edge.

Reset
REQ-027 While wb_rst_i=1, the block SHALL force: FSM=IDLE, wbs_ack_o=0, wbs_dat_o=0, sm_tready=0, pointers=0, count=0, underflow=0, frame_cnt=0, irq_o=0. FIFO storage contents need no reset.
REQ-028 Reset asserted mid-transaction SHALL abort it without an ack. After release, sm_tready=1 on the first cycle.

Verification
REQ-029 Push 3 beats 0x11, 0x22, 0x33 (last on 0x33), then read STATUS -> 0x0001_0003 (bit11=0); irq_o=1.
REQ-030 Perform 3 DATA reads -> 0x11, 0x22, 0x33. A 4th read -> 0; STATUS bit12=1, bit9=1.
REQ-031 Hold sm_tvalid=1 for DEPTH+4 cycles with no reads -> exactly 16 pushes; sm_tready=0 after the 16th; STATUS full=1, count=16. A pop then re-raises sm_tready and one more beat is accepted.
REQ-032 Pop on the same edge as a push with count=5 -> count stays 5; data order is preserved across pointer wrap-around.
REQ-033 Write CTRL=0x7 while sm_tvalid=1 with count=4 -> count=0, frame_cnt=0, underflow=0; the beat in that cycle is not accepted; irq_o=0 on the next edge.
REQ-034 Assert wb_rst_i during the ACK cycle of a DATA read -> wbs_ack_o drops immediately; all STATUS fields read 0 after release.

Source files
------------

// File: rtl/fir_out_fifo_wb.sv
// fir_out_fifo_wb
//   Buffers the FIR's AXI-Stream output in a small circular FIFO and exposes
//   it to a Wishbone master. Each FIFO entry holds {tlast, tdata}.
//
//   Register map (byte addresses):
//     0x104 DATA   (R)  pop head entry data; 0 and sticky underflow when empty
//     0x108 STATUS (R)  [8:0] count, [9] empty, [10] full, [11] head tlast,
//                       [12] underflow, [31:16] frame_cnt
//     0x10C CTRL   (W)  [0] flush, [1] clear underflow, [2] clear frame_cnt
//                       (acts only when wbs_sel_i[0] is set)
//   Every other access acks after one cycle, reads 0 and ignores writes.
//
//   Ports
//     wb_clk_i, wb_rst_i                 clock, async active-high reset
//     wbs_cyc_i/stb_i/we_i/sel_i/adr_i/dat_i, wbs_ack_o/dat_o
//                                        Wishbone slave
//     sm_tvalid/sm_tdata/sm_tlast/sm_tready
//                                        FIR stream input
//     irq_o                              level irq: frames pending or underflow
module fir_out_fifo_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 16
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [ADDR_WIDTH-1:0] wbs_adr_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic                  sm_tvalid,
  input  logic [DATA_WIDTH-1:0] sm_tdata,
  input  logic                  sm_tlast,
  output logic                  sm_tready,
  output logic                  irq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADR_DATA   = ADDR_WIDTH'(12'h104);
  localparam logic [ADDR_WIDTH-1:0] ADR_STATUS = ADDR_WIDTH'(12'h108);
  localparam logic [ADDR_WIDTH-1:0] ADR_CTRL   = ADDR_WIDTH'(12'h10C);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;

  logic                  empty, full;
  logic                  wb_start, ctrl_wr, flush_accept, clr_uf, clr_frame;
  logic                  data_rd, pop, push;
  logic [DATA_WIDTH:0]   head;
  logic                  head_last;
  logic [31:0]           status_w;
  logic                  unused_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // A transaction is taken only from IDLE, so each request is seen once.
  assign wb_start     = (state_q == S_IDLE) && wbs_cyc_i && wbs_stb_i;
  assign ctrl_wr      = wb_start && wbs_we_i && (wbs_adr_i == ADR_CTRL) && wbs_sel_i[0];
  assign flush_accept = ctrl_wr && wbs_dat_i[0];
  assign clr_uf       = ctrl_wr && wbs_dat_i[1];
  assign clr_frame    = ctrl_wr && wbs_dat_i[2];
  assign data_rd      = wb_start && !wbs_we_i && (wbs_adr_i == ADR_DATA);
  assign pop          = data_rd && !empty;

  // Ready drops during a flush so no beat can slip in behind the pointer reset.
  assign sm_tready = !full && !wb_rst_i && !flush_accept;
  assign push      = sm_tvalid && sm_tready;

  assign head      = mem_q[rd_ptr_q];
  assign head_last = !empty && head[DATA_WIDTH];
  assign status_w  = {frame_cnt_q, 3'b000, underflow_q, head_last, full, empty, 9'(count_q)};

  assign wbs_ack_o = (state_q == S_ACK);
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  assign unused_ok = &{1'b0, wbs_sel_i[3:1], wbs_dat_i[DATA_WIDTH-1:3]};

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    frame_cnt_d = frame_cnt_q;
    dat_d       = '0;

    case (state_q)
      S_IDLE:  if (wb_start) state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase

    // Read data is captured on the request edge and cleared when ACK ends.
    if (wb_start && !wbs_we_i) begin
      if (wbs_adr_i == ADR_DATA && !empty) dat_d = head[DATA_WIDTH-1:0];
      else if (wbs_adr_i == ADR_STATUS)    dat_d = DATA_WIDTH'(status_w);
    end

    if (flush_accept) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    if (clr_uf)                  underflow_d = 1'b0;
    else if (data_rd && empty)   underflow_d = 1'b1;

    if (clr_frame)               frame_cnt_d = '0;
    else if (push && sm_tlast)   frame_cnt_d = frame_cnt_q + 16'd1;

    irq_d = (frame_cnt_d != '0) || underflow_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      frame_cnt_q <= '0;
      irq_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      frame_cnt_q <= frame_cnt_d;
      irq_q       <= irq_d;
      dat_q       <= dat_d;
    end
  end

  // Storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {sm_tlast, sm_tdata};
  end

endmodule

// File: tb/tb_fir_out_fifo_wb.sv
module tb_fir_out_fifo_wb;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int DEPTH = 16;

  localparam logic [AW-1:0] A_DATA   = 12'h104;
  localparam logic [AW-1:0] A_STATUS = 12'h108;
  localparam logic [AW-1:0] A_CTRL   = 12'h10C;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [AW-1:0] wbs_adr_i = '0;
  logic [DW-1:0] wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [DW-1:0] wbs_dat_o;
  logic          sm_tvalid = 1'b0;
  logic [DW-1:0] sm_tdata = '0;
  logic          sm_tlast = 1'b0;
  logic          sm_tready;
  logic          irq_o;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  fir_out_fifo_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready), .irq_o(irq_o)
  );

  // Bus cycle: request edge, ack cycle, back to idle. The stream valid is
  // dropped after the request edge so a beat staged alongside it is one beat.
  task automatic wb_read(input logic [AW-1:0] adr, output logic [DW-1:0] d);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = adr;
    @(posedge wb_clk_i); #1;
    sm_tvalid = 1'b0;
    n_cmp++;
    if (wbs_ack_o !== 1'b1) begin
      n_mis++; $display("FAIL rd_ack adr=%h got=%b want=1", adr, wbs_ack_o);
    end
    d = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== '0) begin
      n_mis++; $display("FAIL rd_idle adr=%h ack=%b dat=%h want 0/0", adr, wbs_ack_o, wbs_dat_o);
    end
  endtask

  task automatic wb_write(input logic [AW-1:0] adr, input logic [DW-1:0] d, input logic [3:0] sel);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = adr;
    wbs_dat_i = d; wbs_sel_i = sel;
    @(posedge wb_clk_i); #1;
    sm_tvalid = 1'b0;
    n_cmp++;
    if (wbs_ack_o !== 1'b1) begin
      n_mis++; $display("FAIL wr_ack adr=%h got=%b want=1", adr, wbs_ack_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    @(posedge wb_clk_i); #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic last);
    sm_tvalid = 1'b1; sm_tdata = d; sm_tlast = last;
    #1;
    n_cmp++;
    if (sm_tready !== 1'b1) begin
      n_mis++; $display("FAIL push_ready data=%h got=%b want=1", d, sm_tready);
    end
    @(posedge wb_clk_i); #1;
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    n_cmp++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== '0 || sm_tready !== 1'b0 || irq_o !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_outputs ack=%b dat=%h rdy=%b irq=%b want 0/0/0/0",
               wbs_ack_o, wbs_dat_o, sm_tready, irq_o);
    end
    wb_rst_i = 1'b0;
    #1;
    n_cmp++;
    if (sm_tready !== 1'b1) begin
      n_mis++; $display("FAIL reset_release_ready got=%b want=1", sm_tready);
    end
    @(posedge wb_clk_i); #1;
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0200) begin
      n_mis++; $display("FAIL reset_status got=%h want=00000200", d);
    end
  endtask

  task automatic test_push_status();
    logic [DW-1:0] d;
    push_beat(32'h11, 1'b0);
    push_beat(32'h22, 1'b0);
    push_beat(32'h33, 1'b1);
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0001_0003) begin
      n_mis++; $display("FAIL push_status got=%h want=00010003", d);
    end
    n_cmp++;
    if (irq_o !== 1'b1) begin
      n_mis++; $display("FAIL push_irq got=%b want=1", irq_o);
    end
  endtask

  task automatic test_data_read();
    logic [DW-1:0] d;
    logic [DW-1:0] exp_v [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        wb_read(A_STATUS, d);
        n_cmp++;
        if (d !== 32'h0001_0801) begin
          n_mis++; $display("FAIL head_tlast_status got=%h want=00010801", d);
        end
      end
      wb_read(A_DATA, d);
      n_cmp++;
      if (d !== exp_v[i]) begin
        n_mis++; $display("FAIL data_read%0d got=%h want=%h", i, d, exp_v[i]);
      end
    end
    wb_read(A_DATA, d);
    n_cmp++;
    if (d !== '0) begin
      n_mis++; $display("FAIL underflow_data got=%h want=0", d);
    end
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0001_1200) begin
      n_mis++; $display("FAIL underflow_status got=%h want=00011200", d);
    end
    wb_write(A_CTRL, 32'h6, 4'h1);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_mis++; $display("FAIL clear_irq got=%b want=0", irq_o);
    end
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0200) begin
      n_mis++; $display("FAIL clear_status got=%h want=00000200", d);
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] d;
    int pushes = 0;
    sm_tvalid = 1'b1; sm_tlast = 1'b0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      sm_tdata = 32'h100 + pushes;
      #1;
      if (sm_tready) pushes++;
      @(posedge wb_clk_i); #1;
    end
    n_cmp++;
    if (pushes != DEPTH || sm_tready !== 1'b0) begin
      n_mis++; $display("FAIL full_pushes got=%0d rdy=%b want=%0d rdy=0", pushes, sm_tready, DEPTH);
    end
    sm_tvalid = 1'b0;
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0410) begin
      n_mis++; $display("FAIL full_status got=%h want=00000410", d);
    end
    wb_read(A_DATA, d);
    n_cmp++;
    if (d !== 32'h100 || sm_tready !== 1'b1) begin
      n_mis++; $display("FAIL full_pop got=%h rdy=%b want=00000100 rdy=1", d, sm_tready);
    end
    push_beat(32'h200, 1'b0);
    n_cmp++;
    if (sm_tready !== 1'b0) begin
      n_mis++; $display("FAIL refill_ready got=%b want=0", sm_tready);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      logic [DW-1:0] e;
      e = (i == DEPTH) ? 32'h200 : 32'h100 + i;
      wb_read(A_DATA, d);
      n_cmp++;
      if (d !== e) begin
        n_mis++; $display("FAIL wrap_order%0d got=%h want=%h", i, d, e);
      end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [DW-1:0] d;
    for (int i = 0; i < 5; i++) push_beat(32'h51 + i, 1'b0);
    sm_tvalid = 1'b1; sm_tdata = 32'h56; sm_tlast = 1'b0;
    wb_read(A_DATA, d);
    n_cmp++;
    if (d !== 32'h51) begin
      n_mis++; $display("FAIL simul_pop_data got=%h want=00000051", d);
    end
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0005) begin
      n_mis++; $display("FAIL simul_count got=%h want=00000005", d);
    end
    for (int i = 0; i < 5; i++) begin
      wb_read(A_DATA, d);
      n_cmp++;
      if (d !== 32'h52 + i) begin
        n_mis++; $display("FAIL simul_order%0d got=%h want=%h", i, d, 32'h52 + i);
      end
    end
  endtask

  task automatic test_flush();
    logic [DW-1:0] d;
    wb_read(A_DATA, d);
    for (int i = 0; i < 4; i++) push_beat(32'h61 + i, i == 3);
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0001_1004 || irq_o !== 1'b1) begin
      n_mis++; $display("FAIL preflush_status got=%h irq=%b want=00011004 irq=1", d, irq_o);
    end
    wb_write(A_CTRL, 32'h7, 4'hE);
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0001_1004) begin
      n_mis++; $display("FAIL sel0_ignored got=%h want=00011004", d);
    end
    sm_tvalid = 1'b1; sm_tdata = 32'h99; sm_tlast = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = A_CTRL;
    wbs_dat_i = 32'h7; wbs_sel_i = 4'h1;
    #1;
    n_cmp++;
    if (sm_tready !== 1'b0) begin
      n_mis++; $display("FAIL flush_ready got=%b want=0", sm_tready);
    end
    @(posedge wb_clk_i); #1;
    sm_tvalid = 1'b0; sm_tlast = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_mis++; $display("FAIL flush_irq got=%b want=0", irq_o);
    end
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0200) begin
      n_mis++; $display("FAIL flush_status got=%h want=00000200", d);
    end
  endtask

  task automatic test_clear_race_and_decode();
    logic [DW-1:0] d;
    sm_tvalid = 1'b1; sm_tdata = 32'h77; sm_tlast = 1'b1;
    wb_write(A_CTRL, 32'h4, 4'h1);
    n_cmp++;
    if (irq_o !== 1'b0) begin
      n_mis++; $display("FAIL clear_race_irq got=%b want=0", irq_o);
    end
    wb_write(A_STATUS, 32'h7, 4'h1);
    wb_write(A_DATA, 32'h7, 4'h1);
    wb_write(12'h200, 32'h7, 4'hF);
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0801) begin
      n_mis++; $display("FAIL clear_race_status got=%h want=00000801", d);
    end
    wb_read(A_CTRL, d);
    n_cmp++;
    if (d !== '0) begin
      n_mis++; $display("FAIL ctrl_read got=%h want=0", d);
    end
    wb_read(12'h200, d);
    n_cmp++;
    if (d !== '0) begin
      n_mis++; $display("FAIL unmapped_read got=%h want=0", d);
    end
    wb_read(A_DATA, d);
    n_cmp++;
    if (d !== 32'h77) begin
      n_mis++; $display("FAIL race_beat_data got=%h want=00000077", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    push_beat(32'hAB, 1'b1);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A_DATA;
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'hAB) begin
      n_mis++; $display("FAIL mid_ack ack=%b dat=%h want 1/000000ab", wbs_ack_o, wbs_dat_o);
    end
    wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== '0 || sm_tready !== 1'b0 || irq_o !== 1'b0) begin
      n_mis++;
      $display("FAIL mid_reset ack=%b dat=%h rdy=%b irq=%b want 0/0/0/0",
               wbs_ack_o, wbs_dat_o, sm_tready, irq_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    #1;
    n_cmp++;
    if (sm_tready !== 1'b1 || wbs_ack_o !== 1'b0) begin
      n_mis++; $display("FAIL mid_release rdy=%b ack=%b want 1/0", sm_tready, wbs_ack_o);
    end
    @(posedge wb_clk_i); #1;
    wb_read(A_STATUS, d);
    n_cmp++;
    if (d !== 32'h0000_0200) begin
      n_mis++; $display("FAIL mid_status got=%h want=00000200", d);
    end
  endtask

  initial begin
    test_reset();
    test_push_status();
    test_data_read();
    test_full();
    test_simul_push_pop();
    test_flush();
    test_clear_race_and_decode();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
